// File: rtl/mult_pipe_if.sv
// Issue, bypass-query and write-back bundle of the multiply pipeline.
// master = issuer / bypass controller / write-back side, slave = mult_pipe.
interface mult_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              issue_valid_i;
    logic [DATA_W-1:0] issue_a_i;
    logic [DATA_W-1:0] issue_b_i;
    logic [ADDR_W-1:0] issue_addr_i;
    logic              issue_we_i;
    logic [31:0]       issue_instr_i;
    logic [31:0]       issue_pc_i;

    logic [ADDR_W-1:0] rd_addr_a_i;
    logic [ADDR_W-1:0] rd_addr_b_i;
    logic              hit_a_o;
    logic              ready_a_o;
    logic [DATA_W-1:0] data_a_o;
    logic              hit_b_o;
    logic              ready_b_o;
    logic [DATA_W-1:0] data_b_o;

    logic              wb_valid_o;
    logic              wb_we_o;
    logic [ADDR_W-1:0] wb_addr_o;
    logic [DATA_W-1:0] wb_data_o;
    logic [31:0]       wb_instr_o;
    logic [31:0]       wb_pc_o;

    modport master (
        output issue_valid_i, issue_a_i, issue_b_i, issue_addr_i, issue_we_i,
               issue_instr_i, issue_pc_i, rd_addr_a_i, rd_addr_b_i,
        input  hit_a_o, ready_a_o, data_a_o, hit_b_o, ready_b_o, data_b_o,
               wb_valid_o, wb_we_o, wb_addr_o, wb_data_o, wb_instr_o, wb_pc_o
    );

    modport slave (
        input  issue_valid_i, issue_a_i, issue_b_i, issue_addr_i, issue_we_i,
               issue_instr_i, issue_pc_i, rd_addr_a_i, rd_addr_b_i,
        output hit_a_o, ready_a_o, data_a_o, hit_b_o, ready_b_o, data_b_o,
               wb_valid_o, wb_we_o, wb_addr_o, wb_data_o, wb_instr_o, wb_pc_o
    );
endinterface

// File: rtl/mult_pipe.sv
// DEPTH-stage low-half multiply pipe with bypass query; result on wb_* DEPTH-1 edges after issue.
// stall_i freezes every stage, flush_i drops all valid ops; MULT_PIPE_PERF_EN adds perf counters.
module mult_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 5
) (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic        stall_i,
    input  logic        flush_i,
    mult_pipe_if.slave  bus_io
`ifdef MULT_PIPE_PERF_EN
    ,
    output logic [31:0] perf_issued_o,
    output logic [31:0] perf_retired_o,
    output logic [31:0] perf_flushed_o
`endif
);

    typedef struct packed {
        logic              vld;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
        logic [31:0]       instr;
        logic [31:0]       pc;
    } stage_t;

    stage_t            stage_q [DEPTH];
    stage_t            stage_d [DEPTH];
    logic [DATA_W-1:0] prod_c;

    assign prod_c = bus_io.issue_a_i * bus_io.issue_b_i;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) stage_d[k] = stage_q[k];
        if (flush_i) begin
            for (int k = 0; k < DEPTH; k++) stage_d[k].vld = 1'b0;
        end else if (!stall_i) begin
            for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
            stage_d[0].vld   = bus_io.issue_valid_i;
            stage_d[0].we    = bus_io.issue_we_i;
            stage_d[0].addr  = bus_io.issue_addr_i;
            stage_d[0].dat   = prod_c;
            stage_d[0].instr = bus_io.issue_instr_i;
            stage_d[0].pc    = bus_io.issue_pc_i;
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= stage_d[k];
        end
    end

    // Youngest match wins; only the last stage holds a finished product.
    function automatic logic [DATA_W+1:0] query(input logic [ADDR_W-1:0] rd);
        logic hit;
        logic rdy;
        int   idx;
        hit = 1'b0;
        idx = 0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (stage_q[k].vld && stage_q[k].we && (stage_q[k].addr == rd) && (rd != '0)) begin
                hit = 1'b1;
                idx = k;
            end
        end
        rdy = hit && (idx == DEPTH - 1);
        return {hit, rdy, (rdy ? stage_q[DEPTH-1].dat : {DATA_W{1'b0}})};
    endfunction

    assign {bus_io.hit_a_o, bus_io.ready_a_o, bus_io.data_a_o} = query(bus_io.rd_addr_a_i);
    assign {bus_io.hit_b_o, bus_io.ready_b_o, bus_io.data_b_o} = query(bus_io.rd_addr_b_i);

    assign bus_io.wb_valid_o = stage_q[DEPTH-1].vld;
    assign bus_io.wb_we_o    = stage_q[DEPTH-1].vld & stage_q[DEPTH-1].we;
    assign bus_io.wb_addr_o  = stage_q[DEPTH-1].addr;
    assign bus_io.wb_data_o  = stage_q[DEPTH-1].dat;
    assign bus_io.wb_instr_o = stage_q[DEPTH-1].instr;
    assign bus_io.wb_pc_o    = stage_q[DEPTH-1].pc;

`ifdef MULT_PIPE_PERF_EN
    logic [31:0] perf_issued_q,  perf_issued_d;
    logic [31:0] perf_retired_q, perf_retired_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;
    logic [5:0]  n_vld_c;

    function automatic logic [31:0] sat_add(input logic [31:0] c, input logic [5:0] n);
        logic [32:0] s;
        s = {1'b0, c} + 33'(n);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_comb begin
        n_vld_c = '0;
        for (int k = 0; k < DEPTH; k++) n_vld_c = n_vld_c + 6'(stage_q[k].vld);
        perf_issued_d  = sat_add(perf_issued_q,
                                 6'(bus_io.issue_valid_i & ~stall_i & ~flush_i));
        perf_retired_d = sat_add(perf_retired_q,
                                 6'(stage_q[DEPTH-1].vld & ~stall_i & ~flush_i));
        perf_flushed_d = sat_add(perf_flushed_q, flush_i ? n_vld_c : 6'd0);
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            perf_issued_q  <= '0;
            perf_retired_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_issued_q  <= perf_issued_d;
            perf_retired_q <= perf_retired_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_issued_o  = perf_issued_q;
    assign perf_retired_o = perf_retired_q;
    assign perf_flushed_o = perf_flushed_q;
`endif

endmodule

// File: tb/tb_mult_pipe.sv
// Bench for mult_pipe: directed vector table, hand-written stall/flush/bypass sequences,
// then random traffic, all cross-checked against an in-flight-op queue model.
module tb_mult_pipe;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 5;

    logic clk = 1'b0;
    logic rsn;
    logic stall;
    logic flush;
    always #5 clk = ~clk;

    mult_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

`ifdef MULT_PIPE_PERF_EN
    logic [31:0] perf_issued, perf_retired, perf_flushed;
    longint      m_issued = 0, m_retired = 0, m_flushed = 0;
`endif

    mult_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .rsn_i   (rsn),
        .stall_i (stall),
        .flush_i (flush),
        .bus_io  (bus)
`ifdef MULT_PIPE_PERF_EN
        ,
        .perf_issued_o  (perf_issued),
        .perf_retired_o (perf_retired),
        .perf_flushed_o (perf_flushed)
`endif
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] prod;
        logic [31:0]   instr;
        logic [31:0]   pc;
        int            age;
    } op_t;
    op_t q[$];

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vt[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic st, input logic fl,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        bus.issue_valid_i = v;
        bus.issue_we_i    = we;
        bus.issue_addr_i  = addr;
        bus.issue_a_i     = a;
        bus.issue_b_i     = b;
        bus.issue_instr_i = $urandom;
        bus.issue_pc_i    = $urandom;
        bus.rd_addr_a_i   = ra;
        bus.rd_addr_b_i   = rb;
        stall             = st;
        flush             = fl;
    endtask

    task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, ra, rb);
    endtask

    // Reference bypass: newest in-flight writer of rd decides; finished only at age DEPTH.
    task automatic model_query(input logic [AW-1:0] rd, output logic hit,
                               output logic rdy, output logic [DW-1:0] dat);
        hit = 1'b0; rdy = 1'b0; dat = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!hit && rd != 0 && q[i].we && q[i].addr == rd) begin
                hit = 1'b1;
                rdy = (q[i].age == DEPTH);
                dat = rdy ? q[i].prod : '0;
            end
        end
    endtask

    function automatic logic model_wb_valid();
        return (q.size() > 0) && (q[0].age == DEPTH);
    endfunction

    task automatic check_model();
        logic          h, r;
        logic [DW-1:0] d;
        logic          v;
        v = model_wb_valid();
        chk("wb_valid", 64'(bus.wb_valid_o), 64'(v));
        chk("wb_we", 64'(bus.wb_we_o), 64'(v && q[0].we));
        if (v) begin
            chk("wb_addr", 64'(bus.wb_addr_o), 64'(q[0].addr));
            chk("wb_data", 64'(bus.wb_data_o), 64'(q[0].prod));
            chk("wb_instr", 64'(bus.wb_instr_o), 64'(q[0].instr));
            chk("wb_pc", 64'(bus.wb_pc_o), 64'(q[0].pc));
        end
        model_query(bus.rd_addr_a_i, h, r, d);
        chk("hit_a", 64'(bus.hit_a_o), 64'(h));
        chk("ready_a", 64'(bus.ready_a_o), 64'(r));
        chk("data_a", 64'(bus.data_a_o), 64'(d));
        model_query(bus.rd_addr_b_i, h, r, d);
        chk("hit_b", 64'(bus.hit_b_o), 64'(h));
        chk("ready_b", 64'(bus.ready_b_o), 64'(r));
        chk("data_b", 64'(bus.data_b_o), 64'(d));
`ifdef MULT_PIPE_PERF_EN
        chk("perf_issued", 64'(perf_issued), 64'(m_issued));
        chk("perf_retired", 64'(perf_retired), 64'(m_retired));
        chk("perf_flushed", 64'(perf_flushed), 64'(m_flushed));
`endif
    endtask

    task automatic model_edge();
        op_t         o;
        logic [63:0] full;
        logic        ret;
        ret = model_wb_valid();
        if (flush) begin
`ifdef MULT_PIPE_PERF_EN
            m_flushed += q.size();
`endif
            q.delete();
        end else if (!stall) begin
`ifdef MULT_PIPE_PERF_EN
            if (ret) m_retired++;
            if (bus.issue_valid_i) m_issued++;
`endif
            foreach (q[i]) q[i].age++;
            while (q.size() > 0 && q[0].age > DEPTH) void'(q.pop_front());
            if (bus.issue_valid_i) begin
                full    = 64'(bus.issue_a_i) * 64'(bus.issue_b_i);
                o.we    = bus.issue_we_i;
                o.addr  = bus.issue_addr_i;
                o.prod  = full[DW-1:0];
                o.instr = bus.issue_instr_i;
                o.pc    = bus.issue_pc_i;
                o.age   = 1;
                q.push_back(o);
            end
        end
    endtask

    // Inputs are already set at the negedge; check the current state, then take one edge.
    task automatic step();
        #1;
        check_model();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wb_valid"}, 64'(bus.wb_valid_o), 64'd0);
        chk({tag, "_wb_we"}, 64'(bus.wb_we_o), 64'd0);
        chk({tag, "_wb_addr"}, 64'(bus.wb_addr_o), 64'd0);
        chk({tag, "_wb_data"}, 64'(bus.wb_data_o), 64'd0);
        chk({tag, "_wb_instr"}, 64'(bus.wb_instr_o), 64'd0);
        chk({tag, "_wb_pc"}, 64'(bus.wb_pc_o), 64'd0);
        chk({tag, "_hit_a"}, 64'(bus.hit_a_o), 64'd0);
        chk({tag, "_hit_b"}, 64'(bus.hit_b_o), 64'd0);
        chk({tag, "_data_a"}, 64'(bus.data_a_o), 64'd0);
    endtask

    initial begin
        vt[0] = '{32'd7, 32'd6, 32'd42};
        vt[1] = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE};
        vt[2] = '{32'h0001_0000, 32'h0001_0000, 32'h0};
        vt[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1};
        vt[4] = '{32'd12345, 32'd0, 32'h0};
        vt[5] = '{32'h8000_0000, 32'd3, 32'h8000_0000};

        // Reset with garbage on the inputs: nothing may leak through.
        rsn = 1'b0;
        drive(1'b1, 1'b1, 5'd3, 32'd9, 32'd9, 1'b0, 1'b0, 5'd3, 5'd3);
        #12;
        chk_all_zero("in_reset");
        @(negedge clk);
        idle(5'd3, 5'd0);
        rsn = 1'b1;
        #1;
        chk_all_zero("after_reset");
        @(negedge clk);

        // Vector table: latency exactly DEPTH-1 edges after the issue edge.
        foreach (vt[i]) begin
            drive(1'b1, 1'b1, 5'd3, vt[i].a, vt[i].b, 1'b0, 1'b0, 5'd0, 5'd0);
            step();
            for (int c = 0; c < DEPTH; c++) begin
                idle(5'd0, 5'd0);
                #1;
                chk($sformatf("vec%0d_c%0d_valid", i, c), 64'(bus.wb_valid_o), 64'(c == DEPTH - 1));
                if (c == DEPTH - 1) begin
                    chk($sformatf("vec%0d_data", i), 64'(bus.wb_data_o), 64'(vt[i].exp));
                    chk($sformatf("vec%0d_addr", i), 64'(bus.wb_addr_o), 64'd3);
                end else if (i == 0) begin
                    chk($sformatf("vec0_c%0d_data_zero", c), 64'(bus.wb_data_o), 64'd0);
                end
                step();
            end
        end

        // Bypass: not forwardable until the op sits in the last stage.
        drive(1'b1, 1'b1, 5'd5, 32'd9, 32'd11, 1'b0, 1'b0, 5'd5, 5'd0);
        step();
        for (int c = 0; c < DEPTH; c++) begin
            idle(5'd5, 5'd0);
            #1;
            chk($sformatf("byp_c%0d_hit", c), 64'(bus.hit_a_o), 64'd1);
            chk($sformatf("byp_c%0d_ready", c), 64'(bus.ready_a_o), 64'(c == DEPTH - 1));
            chk($sformatf("byp_c%0d_data", c), 64'(bus.data_a_o), (c == DEPTH - 1) ? 64'd99 : 64'd0);
            chk($sformatf("byp_c%0d_zero_hit", c), 64'(bus.hit_b_o), 64'd0);
            step();
        end

        // Two writers of r4: the younger (20) owns the bypass.
        drive(1'b1, 1'b1, 5'd4, 32'd2, 32'd5, 1'b0, 1'b0, 5'd0, 5'd4);
        step();
        drive(1'b1, 1'b1, 5'd4, 32'd4, 32'd5, 1'b0, 1'b0, 5'd0, 5'd4);
        step();
        for (int c = 0; c < DEPTH + 1; c++) begin
            idle(5'd0, 5'd4);
            #1;
            if (c == DEPTH - 2) begin
                chk("ww_old_at_wb_valid", 64'(bus.wb_data_o), 64'd10);
                chk("ww_old_at_wb_ready", 64'(bus.ready_b_o), 64'd0);
                chk("ww_old_at_wb_hit", 64'(bus.hit_b_o), 64'd1);
            end
            if (c == DEPTH - 1) begin
                chk("ww_new_ready", 64'(bus.ready_b_o), 64'd1);
                chk("ww_new_data", 64'(bus.data_b_o), 64'd20);
            end
            step();
        end

        // Three ops in flight, then 3 stall edges: each retires 3 edges late, in order.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 5'(k + 1), 32'(k + 2), 32'd3, 1'b0, 1'b0, 5'd1, 5'd3);
            step();
        end
        for (int n = 2; n < 12; n++) begin
            drive(1'b0, 1'b0, '0, '0, '0, (n >= 2 && n <= 4), 1'b0, 5'd1, 5'd3);
            #1;
            chk($sformatf("stall_n%0d_valid", n), 64'(bus.wb_valid_o), 64'(n >= 7 && n <= 9));
            if (n >= 7 && n <= 9)
                chk($sformatf("stall_n%0d_addr", n), 64'(bus.wb_addr_o), 64'(n - 6));
            step();
        end

        // Flush with a simultaneous issue: nothing in flight ever retires.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 5'(k + 6), 32'(k + 5), 32'd7, 1'b0, 1'b0, 5'd9, 5'd6);
            step();
        end
        drive(1'b1, 1'b1, 5'd9, 32'd3, 32'd3, 1'b0, 1'b1, 5'd9, 5'd6);
        step();
        for (int c = 0; c < DEPTH + 2; c++) begin
            idle(5'd9, 5'd6);
            #1;
            chk($sformatf("flush_c%0d_valid", c), 64'(bus.wb_valid_o), 64'd0);
            chk($sformatf("flush_c%0d_hit", c), 64'(bus.hit_a_o | bus.hit_b_o), 64'd0);
            step();
        end

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            drive(($urandom_range(0, 9) < 7), 1'($urandom), 5'($urandom_range(0, 7)),
                  (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom)), 32'($urandom),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            step();
        end
        idle(5'd0, 5'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
